approx_mul_arbiter: RTL and testbench
=====================================

APPROX_MUL_ARBITER -- requirements
Module: approx_mul_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1: 1 = round-robin arbitration, 0 = fixed priority with requester 0 highest.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports a_valid / b_valid, input, 1 each, request present from requester A / B.
REQ-005 SHALL have ports a_ready / b_ready, output, 1 each, request accepted this cycle when ready and valid are both high.
REQ-006 SHALL have ports a_x, a_y, b_x, b_y, input, 8 each, unsigned operands.
REQ-007 SHALL have ports a_exact / b_exact, input, 1 each, 1 = exact product, 0 = approximate product.
REQ-008 SHALL have port res_valid, output, 1, result register holds a valid result.
REQ-009 SHALL have port res_ready, input, 1, consumer accepts the result when res_valid and res_ready are both high.
REQ-010 SHALL have port res_z, output, 16, product.
REQ-011 SHALL have port res_id, output, 1, source of the result: 0 = A, 1 = B.
REQ-012 SHALL have port approx_cnt, output, 16, count of approximate results delivered.

Function
REQ-013 SHALL be a two-stage pipeline: S1 holds the accepted operands, id and exact flag; S2 is the result register driving the res_* outputs.
REQ-014 SHALL compute the approximate product as (y * x[7:2]) << 2 plus a correction word that is zero except: bit6 = (y[5]&x[0]) | (y[4]&x[1]); bit7 = (y[7]&x[0]) | (y[6]&x[1]); bit8 = y[7]&x[1]; 16-bit unsigned addition with no overflow.
REQ-015 SHALL compute the exact product as the full 16-bit unsigned x*y.
REQ-016 SHALL evaluate the product combinationally from S1 and load it into S2 on the S1->S2 advance.
REQ-017 SHALL advance S1->S2 when S1 is valid and S2 is either empty or being drained this cycle.
REQ-018 SHALL accept a new request into S1 when S1 is empty or S1 advances this cycle, giving full throughput of one result per cycle with no bubbles.
REQ-019 SHALL assert at most one of a_ready/b_ready per cycle.
REQ-020 SHALL make ready depend only on the valid inputs and internal state, never on operand or exact inputs.
REQ-021 SHALL, with RR_EN=1, keep a last-grant bit (reset 1, so A wins the first tie); on a tie, grant the requester not last granted; the bit updates only on an actual acceptance.
REQ-022 SHALL, with RR_EN=0, always grant A on a tie.
REQ-023 SHALL give a latency of 2 cycles: a request accepted at edge N gives res_valid high after edge N+1 when S2 is free.
REQ-024 SHALL hold res_z and res_id stable while res_valid=1 and res_ready=0, and SHALL stall S1 and deassert both readies when S1 and S2 are both full.
REQ-025 SHALL increment approx_cnt on each result handshake whose exact flag was 0, and SHALL saturate it at 16'hFFFF.

Reset
REQ-026 SHALL, while rst is high, force res_valid=0, res_z=0, res_id=0, approx_cnt=0, both stage-valid flags 0 and last-grant=1, immediately and without a clock edge.
REQ-027 SHALL drop any in-flight requests on a reset asserted mid-operation; no result appears for them after release.
REQ-028 SHALL permit readies to assert in the first cycle after rst deasserts.

Verification
REQ-029 SHALL cover: A only, x=3, y=5, exact=0, res_ready=1 -> res_z=0, res_id=0, 2 cycles after acceptance; approx_cnt goes to 1.
REQ-030 SHALL cover: A only, x=255, y=255, exact=0 -> res_z=64708; repeated with exact=1 -> res_z=65025, approx_cnt unchanged.
REQ-031 SHALL cover: A and B valid every cycle, RR_EN=1, res_ready=1 -> grants A,B,A,B..., res_id alternates 0,1,0,1; with RR_EN=0 -> all grants A.
REQ-032 SHALL cover: res_ready=0 for 5 cycles with continuous requests -> two requests accepted, then both readies 0; res_z held; on release, results drain in order with no loss or duplicate.
REQ-033 SHALL cover: rst pulsed while S1 and S2 are full -> outputs zero within the reset cycle; no stale result afterwards.
REQ-034 SHALL cover: approx_cnt preloaded near saturation by 65536 approximate results -> approx_cnt holds at 65535.

Source files
------------

// File: rtl/approx_mul_arbiter.sv
// approx_mul_arbiter: two-requester arbiter in front of a two-stage
// exact/approximate 8x8 unsigned multiplier.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   a_valid/a_ready, a_x, a_y,   requester A handshake, operands and
//   a_exact                      exact(1)/approximate(0) select
//   b_valid/b_ready, b_x, b_y,   requester B, same meaning
//   b_exact
//   res_valid/res_ready          result handshake
//   res_z                        16-bit product
//   res_id                       result source (0 = A, 1 = B)
//   approx_cnt                   saturating count of delivered approximate results
//
// Parameter RR_EN: 1 = round-robin on ties, 0 = fixed priority (A wins).
module approx_mul_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [7:0]  a_x,
  input  logic [7:0]  a_y,
  input  logic        a_exact,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [7:0]  b_x,
  input  logic [7:0]  b_y,
  input  logic        b_exact,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_z,
  output logic        res_id,
  output logic [15:0] approx_cnt
);

  localparam int unsigned OP_W  = 8;
  localparam int unsigned RES_W = 16;
  localparam int unsigned CNT_W = 16;

  typedef struct packed {
    logic [OP_W-1:0] x;
    logic [OP_W-1:0] y;
    logic            id;
    logic            exact;
  } op_t;

  logic             s1_valid;
  op_t              s1;
  logic             s2_exact;
  logic             last_grant;   // id of the last accepted requester

  logic             s2_drain_c;
  logic             advance_c;
  logic             s1_free_c;
  logic             pick_b_c;
  logic             grant_a_c;
  logic             grant_b_c;
  logic [RES_W-1:0] prod_c;

  // Truncated product: drop x[1:0] partial products, add back a few carries.
  function automatic logic [RES_W-1:0] approx_prod(input logic [OP_W-1:0] x,
                                                   input logic [OP_W-1:0] y);
    logic [RES_W-1:0] base;
    logic [RES_W-1:0] corr;
    base    = {8'd0, y} * {10'd0, x[7:2]};
    corr    = '0;
    corr[6] = (y[5] & x[0]) | (y[4] & x[1]);
    corr[7] = (y[7] & x[0]) | (y[6] & x[1]);
    corr[8] = y[7] & x[1];
    return (base << 2) + corr;
  endfunction

  function automatic logic [RES_W-1:0] exact_prod(input logic [OP_W-1:0] x,
                                                  input logic [OP_W-1:0] y);
    return {8'd0, x} * {8'd0, y};
  endfunction

  // Pipeline flow control and arbitration; readies see only valids and state.
  always_comb begin
    s2_drain_c = res_valid & res_ready;
    advance_c  = s1_valid & (~res_valid | res_ready);
    s1_free_c  = ~s1_valid | advance_c;
    // last_grant=1 means B went last, so a tie goes to A
    pick_b_c   = RR_EN & ~last_grant;
    grant_a_c  = s1_free_c & a_valid & (~b_valid | ~pick_b_c);
    grant_b_c  = s1_free_c & b_valid & (~a_valid | pick_b_c);
    prod_c     = s1.exact ? exact_prod(s1.x, s1.y) : approx_prod(s1.x, s1.y);
  end

  assign a_ready = grant_a_c;
  assign b_ready = grant_b_c;

  // S1 operand stage, S2 result stage, last-grant and approximate counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1         <= '0;
      res_valid  <= 1'b0;
      res_z      <= '0;
      res_id     <= 1'b0;
      s2_exact   <= 1'b0;
      approx_cnt <= '0;
      last_grant <= 1'b1;
    end else begin
      if (advance_c) begin
        res_valid <= 1'b1;
        res_z     <= prod_c;
        res_id    <= s1.id;
        s2_exact  <= s1.exact;
      end else if (s2_drain_c) begin
        res_valid <= 1'b0;
      end

      if (grant_a_c | grant_b_c) begin
        s1_valid   <= 1'b1;
        s1.x       <= grant_b_c ? b_x : a_x;
        s1.y       <= grant_b_c ? b_y : a_y;
        s1.id      <= grant_b_c;
        s1.exact   <= grant_b_c ? b_exact : a_exact;
        last_grant <= grant_b_c;
      end else if (advance_c) begin
        s1_valid <= 1'b0;
      end

      if (s2_drain_c && !s2_exact && (approx_cnt != {CNT_W{1'b1}})) begin
        approx_cnt <= approx_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_approx_mul_arbiter.sv
// Bench for approx_mul_arbiter: a round-robin and a fixed-priority instance
// share all inputs; each is checked every cycle against a transaction-level
// model (in-flight list, last grant, delivered-approximate count).
module tb_approx_mul_arbiter;

  logic        clk;
  logic        rst;
  logic        a_valid, b_valid, a_exact, b_exact, res_ready;
  logic [7:0]  a_x, a_y, b_x, b_y;

  logic        a_rdy [2];
  logic        b_rdy [2];
  logic        rv    [2];
  logic [15:0] rz    [2];
  logic        rid   [2];
  logic [15:0] acnt  [2];

  int checks = 0;
  int errors = 0;

  approx_mul_arbiter #(.RR_EN(1'b1)) dut_rr (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_rdy[0]), .a_x(a_x), .a_y(a_y), .a_exact(a_exact),
    .b_valid(b_valid), .b_ready(b_rdy[0]), .b_x(b_x), .b_y(b_y), .b_exact(b_exact),
    .res_valid(rv[0]), .res_ready(res_ready), .res_z(rz[0]), .res_id(rid[0]),
    .approx_cnt(acnt[0])
  );

  approx_mul_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_rdy[1]), .a_x(a_x), .a_y(a_y), .a_exact(a_exact),
    .b_valid(b_valid), .b_ready(b_rdy[1]), .b_x(b_x), .b_y(b_y), .b_exact(b_exact),
    .res_valid(rv[1]), .res_ready(res_ready), .res_z(rz[1]), .res_id(rid[1]),
    .approx_cnt(acnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d actual=%0d expected=%0d at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Product straight from the arithmetic rules.
  function automatic int model_prod(input int x, input int y, input bit exact);
    int c;
    if (exact) return x * y;
    c = 0;
    if ((((y >> 5) & x & 1) | ((y >> 4) & (x >> 1) & 1)) != 0) c += 64;
    if ((((y >> 7) & x & 1) | ((y >> 6) & (x >> 1) & 1)) != 0) c += 128;
    if (((y >> 7) & (x >> 1) & 1) != 0) c += 256;
    return (y * (x / 4)) * 4 + c;
  endfunction

  typedef struct {
    int x;
    int y;
    bit exact;
    bit id;
    int acc;   // index of the edge at which it was accepted
  } txn_t;

  txn_t fifo [2][4];
  int   head [2];
  int   cnt  [2];
  bit   lg   [2];
  int   ecnt [2];
  int   cyc;

  // Per-cycle compare against the model; the model then steps over the next edge.
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        chk("rst_res_valid", k, int'(rv[k]), 0);
        chk("rst_res_z", k, int'(rz[k]), 0);
        chk("rst_res_id", k, int'(rid[k]), 0);
        chk("rst_approx_cnt", k, int'(acnt[k]), 0);
        head[k] = 0;
        cnt[k]  = 0;
        lg[k]   = 1'b1;
        ecnt[k] = 0;
      end
      cyc = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        txn_t f;
        txn_t n;
        bit   erv, ok, pb, ea, eb;
        f   = fifo[k][head[k]];
        erv = (cnt[k] > 0) && (cyc >= f.acc + 1);
        chk("res_valid", k, int'(rv[k]), int'(erv));
        if (erv) begin
          chk("res_z", k, int'(rz[k]), model_prod(f.x, f.y, f.exact));
          chk("res_id", k, int'(rid[k]), int'(f.id));
        end
        chk("approx_cnt", k, int'(acnt[k]), ecnt[k]);
        ok = (cnt[k] < 2) || res_ready;
        pb = (k == 0) && !lg[k];
        ea = ok && a_valid && (!b_valid || !pb);
        eb = ok && b_valid && (!a_valid || pb);
        chk("a_ready", k, int'(a_rdy[k]), int'(ea));
        chk("b_ready", k, int'(b_rdy[k]), int'(eb));
        if (erv && res_ready) begin
          if (!f.exact && ecnt[k] < 65535) ecnt[k]++;
          head[k] = (head[k] + 1) % 4;
          cnt[k]--;
        end
        if (ea || eb) begin
          n.x     = eb ? int'(b_x) : int'(a_x);
          n.y     = eb ? int'(b_y) : int'(a_y);
          n.exact = eb ? b_exact : a_exact;
          n.id    = eb;
          n.acc   = cyc + 1;
          fifo[k][(head[k] + cnt[k]) % 4] = n;
          cnt[k]++;
          lg[k] = eb;
        end
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    a_x = 8'd0; a_y = 8'd0; a_exact = 1'b0;
    b_x = 8'd0; b_y = 8'd0; b_exact = 1'b0;
    res_ready = 1'b1;

    // Pin the model with hand-computed products.
    chk("model_approx_3x5", 0, model_prod(3, 5, 1'b0), 0);
    chk("model_approx_255x255", 0, model_prod(255, 255, 1'b0), 64708);
    chk("model_exact_255x255", 0, model_prod(255, 255, 1'b1), 65025);

    repeat (3) tick();
    rst = 1'b0;

    // A only, 3*5 approximate
    a_valid = 1'b1; a_x = 8'd3; a_y = 8'd5; a_exact = 1'b0;
    tick();
    idle();
    tick();
    chk("lit_3x5_valid", 0, int'(rv[0]), 1);
    chk("lit_3x5_z", 0, int'(rz[0]), 0);
    chk("lit_3x5_id", 0, int'(rid[0]), 0);
    tick();
    chk("lit_cnt_1", 0, int'(acnt[0]), 1);

    // 255*255 approximate then exact
    a_valid = 1'b1; a_x = 8'd255; a_y = 8'd255; a_exact = 1'b0;
    tick();
    idle();
    tick();
    chk("lit_255_approx", 0, int'(rz[0]), 64708);
    tick();
    chk("lit_cnt_2", 0, int'(acnt[0]), 2);
    a_valid = 1'b1; a_exact = 1'b1;
    tick();
    idle();
    tick();
    chk("lit_255_exact", 0, int'(rz[0]), 65025);
    tick();
    chk("lit_cnt_still_2", 0, int'(acnt[0]), 2);

    // Continuous tie: RR alternates starting with B (A went last), FP always A
    a_valid = 1'b1; b_valid = 1'b1; a_exact = 1'b0; b_exact = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_x = 8'(i + 10); b_x = 8'(i + 20); a_y = 8'(3 * i); b_y = 8'(7 * i);
      #1;
      chk("lit_rr_a", 0, int'(a_rdy[0]), int'(i % 2 == 1));
      chk("lit_rr_b", 0, int'(b_rdy[0]), int'(i % 2 == 0));
      chk("lit_fp_a", 1, int'(a_rdy[1]), 1);
      tick();
    end
    idle();
    repeat (3) tick();

    // Consumer stall with continuous requests: two accepts, then none
    res_ready = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_x = 8'($urandom); a_y = 8'($urandom); b_x = 8'($urandom); b_y = 8'($urandom);
      #1;
      chk("lit_stall_ready", 0, int'(a_rdy[0] | b_rdy[0]), int'(i < 2));
      tick();
    end
    idle();
    res_ready = 1'b1;
    repeat (4) tick();

    // Reset while both stages are full
    res_ready = 1'b0;
    a_valid = 1'b1;
    repeat (3) tick();
    idle();
    rst = 1'b1;
    #1;
    chk("lit_rst_valid", 0, int'(rv[0]), 0);
    chk("lit_rst_z", 0, int'(rz[0]), 0);
    chk("lit_rst_cnt", 0, int'(acnt[0]), 0);
    tick();
    tick();
    rst = 1'b0;
    res_ready = 1'b1;
    a_valid = 1'b1; a_x = 8'd7; a_y = 8'd9; a_exact = 1'b1;
    #1;
    chk("lit_ready_after_rst", 0, int'(a_rdy[0]), 1);
    tick();
    idle();
    repeat (3) tick();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      a_valid = 1'($urandom); b_valid = 1'($urandom);
      a_x = 8'($urandom); a_y = 8'($urandom); a_exact = 1'($urandom);
      b_x = 8'($urandom); b_y = 8'($urandom); b_exact = 1'($urandom);
      res_ready = ($urandom_range(3) != 0);
      tick();
    end
    idle();
    res_ready = 1'b1;
    repeat (4) tick();

    // Saturate the approximate counter
    a_valid = 1'b1; a_exact = 1'b0;
    for (int i = 0; i < 65600; i++) begin
      a_x = 8'($urandom); a_y = 8'($urandom);
      tick();
    end
    idle();
    repeat (3) tick();
    chk("lit_sat_rr", 0, int'(acnt[0]), 65535);
    chk("lit_sat_fp", 1, int'(acnt[1]), 65535);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
